// File: rtl/lte_dl_ant_remap_if.sv
// Stream interface for the downlink antenna-remap buffer: TDM samples in, remapped samples out.
// The master side feeds samples and observes results; the slave side is the remap block.
interface lte_dl_ant_remap_if #(
  parameter int unsigned ANT_NUM = 8,
  parameter int unsigned ANT_W   = 3,
  parameter int unsigned DW      = 32
);
  logic [ANT_NUM*ANT_W-1:0] i_ant_posinfo;
  logic                     i_fram_hd;
  logic [DW-1:0]            i_data;
  logic                     i_data_valid;
  logic                     o_fram_hd;
  logic                     o_ant_sel;
  logic [DW-1:0]            o_data;
  logic                     o_data_valid;
  logic                     o_trunc;
  logic                     o_map_err;

  modport master (
    output i_ant_posinfo, i_fram_hd, i_data, i_data_valid,
    input  o_fram_hd, o_ant_sel, o_data, o_data_valid, o_trunc, o_map_err
  );

  modport slave (
    input  i_ant_posinfo, i_fram_hd, i_data, i_data_valid,
    output o_fram_hd, o_ant_sel, o_data, o_data_valid, o_trunc, o_map_err
  );
endinterface

// File: rtl/lte_dl_ant_remap.sv
// Ping-pong antenna-remap buffer: writes TDM samples through a per-frame position map and
// streams completed banks out in natural order. Define MAP_CHECK_EN to add duplicate-map checking.
module lte_dl_ant_remap #(
  parameter int unsigned ANT_NUM = 8,
  parameter int unsigned ANT_W   = 3,
  parameter int unsigned GRP     = 4,
  parameter int unsigned DW      = 32
) (
  input  logic               clk,
  input  logic               asy_rst_n,
  lte_dl_ant_remap_if.slave  bus
);
  localparam int unsigned N  = ANT_NUM * GRP;
  localparam int unsigned CW = $clog2(N);
  localparam int unsigned MW = ANT_NUM * ANT_W;
  localparam logic [CW-1:0] LastIdx = CW'(N - 1);

  function automatic logic [MW-1:0] ident_map();
    logic [MW-1:0] m;
    m = '0;
    for (int k = 0; k < int'(ANT_NUM); k++) m[k*ANT_W +: ANT_W] = ANT_W'(k);
    return m;
  endfunction

  localparam logic [MW-1:0] IdentMap = ident_map();

  typedef enum logic [0:0] {StIdle, StRead} state_e;

  logic [MW-1:0] map_q, map_src;
  logic [CW-1:0] wcnt_q, wslot, waddr;
  logic          wbank_q, ff_tag_q, trunc_q;
  logic          pend_q, pend_bank_q, pend_ff_q;
  logic          hd, vld, complete, consume, use_ident;

  logic [DW-1:0] mem [2*N];
  logic [DW-1:0] rd_data_q;

  state_e        state_q;
  logic [CW-1:0] rcnt_q;
  logic          rbank_q, rff_q;
  logic          rd_v_q, rd_ant0_q, rd_ff_q;
  logic          out_v_q, out_as_q, out_fh_q;
  logic [DW-1:0] out_d_q;

  assign hd  = bus.i_fram_hd;
  assign vld = bus.i_data_valid;

  // A header restarts the bank at slot 0 and applies the incoming map immediately.
  assign map_src = hd ? bus.i_ant_posinfo : map_q;
  assign wslot   = hd ? '0 : wcnt_q;

  always_comb begin
    waddr = wslot;
    if (!use_ident) waddr[ANT_W-1:0] = map_src[int'(wslot[ANT_W-1:0])*ANT_W +: ANT_W];
  end

  assign complete = vld && !hd && (wcnt_q == LastIdx);
  assign consume  = pend_q && ((state_q == StIdle) || (rcnt_q == LastIdx));

`ifdef MAP_CHECK_EN
  logic chk_q, bad_q, err_q, dup;

  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < int'(ANT_NUM); i++) begin
      for (int j = i + 1; j < int'(ANT_NUM); j++) begin
        if (map_q[i*ANT_W +: ANT_W] == map_q[j*ANT_W +: ANT_W]) dup = 1'b1;
      end
    end
  end

  // Identity stays in force while the new map is being checked and for a bad frame.
  assign use_ident = hd | chk_q | bad_q;

  always_ff @(posedge clk or negedge asy_rst_n) begin
    if (!asy_rst_n) begin
      chk_q <= 1'b0;
      bad_q <= 1'b0;
      err_q <= 1'b0;
    end else if (hd) begin
      chk_q <= 1'b1;
    end else if (chk_q) begin
      chk_q <= 1'b0;
      bad_q <= dup;
      err_q <= dup;
    end
  end

  assign bus.o_map_err = err_q;
`else
  assign use_ident     = 1'b0;
  assign bus.o_map_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge asy_rst_n) begin
    if (!asy_rst_n) begin
      map_q       <= IdentMap;
      wcnt_q      <= '0;
      wbank_q     <= 1'b0;
      ff_tag_q    <= 1'b0;
      trunc_q     <= 1'b0;
      pend_q      <= 1'b0;
      pend_bank_q <= 1'b0;
      pend_ff_q   <= 1'b0;
    end else begin
      trunc_q <= hd && (wcnt_q != '0);
      if (hd) begin
        map_q    <= bus.i_ant_posinfo;
        ff_tag_q <= 1'b1;
        wcnt_q   <= vld ? CW'(1) : '0;
      end else if (vld) begin
        wcnt_q <= wcnt_q + CW'(1);
        if (complete) begin
          wbank_q  <= ~wbank_q;
          ff_tag_q <= 1'b0;
        end
      end
      if (complete) begin
        pend_q      <= 1'b1;
        pend_bank_q <= wbank_q;
        pend_ff_q   <= ff_tag_q;
      end else if (consume) begin
        pend_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (vld) mem[{wbank_q, waddr}] <= bus.i_data;
    rd_data_q <= mem[{rbank_q, rcnt_q}];
  end

  always_ff @(posedge clk or negedge asy_rst_n) begin
    if (!asy_rst_n) begin
      state_q   <= StIdle;
      rcnt_q    <= '0;
      rbank_q   <= 1'b0;
      rff_q     <= 1'b0;
      rd_v_q    <= 1'b0;
      rd_ant0_q <= 1'b0;
      rd_ff_q   <= 1'b0;
      out_v_q   <= 1'b0;
      out_as_q  <= 1'b0;
      out_fh_q  <= 1'b0;
      out_d_q   <= '0;
    end else begin
      rd_v_q    <= (state_q == StRead);
      rd_ant0_q <= (rcnt_q[ANT_W-1:0] == '0);
      rd_ff_q   <= rff_q && (rcnt_q == '0);
      out_v_q   <= rd_v_q;
      out_d_q   <= rd_v_q ? rd_data_q : '0;
      out_as_q  <= rd_v_q && rd_ant0_q;
      out_fh_q  <= rd_v_q && rd_ff_q;
      unique case (state_q)
        StIdle: begin
          if (pend_q) begin
            state_q <= StRead;
            rcnt_q  <= '0;
            rbank_q <= pend_bank_q;
            rff_q   <= pend_ff_q;
          end
        end
        StRead: begin
          rcnt_q <= rcnt_q + CW'(1);
          if (rcnt_q == LastIdx) begin
            if (pend_q) begin
              rbank_q <= pend_bank_q;
              rff_q   <= pend_ff_q;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.o_data_valid = out_v_q;
  assign bus.o_data       = out_d_q;
  assign bus.o_ant_sel    = out_as_q;
  assign bus.o_fram_hd    = out_fh_q;
  assign bus.o_trunc      = trunc_q;
endmodule

// File: doc/lte_dl_ant_remap.md
Name: lte_dl_ant_remap

Overview:
Parametrised downlink antenna-remap buffer for the LTE data path. It takes a TDM stream of per-antenna IQ samples and writes each sample to a buffer slot chosen by a per-frame antenna position map. Each completed bank is then streamed out in natural antenna order. It is single-clock, uses ping-pong banks, supports gapped input, and marks frame and antenna-group boundaries, ahead of the DL framer.

Parameters:
ANT_NUM, 8, antennas per TDM group; power of 2, 2..16
ANT_W, 3, log2(ANT_NUM); width of one map field
GRP, 4, antenna groups per bank; power of 2
DW, 32, sample width {I,Q}

Ports:
clk  input  1  datapath clock
asy_rst_n  input  1  asynchronous active-low reset
i_ant_posinfo  input  ANT_NUM*ANT_W  packed map; field k (bits k*ANT_W +: ANT_W) = buffer position of input slot k
i_fram_hd  input  1  frame header pulse
i_data  input  DW  input sample
i_data_valid  input  1  input sample qualifier
o_fram_hd  output  1  high with first output sample of a frame
o_ant_sel  output  1  high with antenna-0 sample of each output group
o_data  output  DW  remapped sample
o_data_valid  output  1  output qualifier
o_trunc  output  1  1-cycle pulse: partial bank discarded by header
o_map_err  output  1  map invalid (MAP_CHECK_EN only, else tied 0)

Behaviour:
- Reset: asynchronous on asy_rst_n low. All outputs 0, counters 0, write bank 0, read idle, map = identity (field k = k).
- Map is latched only on the i_fram_hd cycle. Between headers it is stable; mid-frame changes of i_ant_posinfo are ignored.
- Write side:
  - slot counter wcnt is log2(ANT_NUM*GRP) bits and advances only on i_data_valid.
  - Sample is written to address {wcnt[high: ANT_W], map[wcnt[ANT_W-1:0]]} of the write bank.
- i_fram_hd handling:
  - The map is latched and wcnt is cleared.
  - If i_data_valid is high in the same cycle, that sample is slot 0 and is written using the newly latched map.
  - If wcnt was nonzero, o_trunc pulses for 1 cycle. The partial bank is discarded: no bank swap, the same bank is rewritten.
  - The next completed bank is tagged frame-first.
- Bank complete (wcnt wraps from ANT_NUM*GRP-1 to 0 on a valid sample):
  - The write bank toggles.
  - The completed bank is queued for read together with its frame-first tag.
- Read side FSM:
  - IDLE -> READ on the cycle after a bank completes.
  - READ lasts exactly ANT_NUM*GRP cycles, reading addresses 0..N-1 in order, then returns to IDLE. It goes directly to READ again if another bank is pending.
  - Pending depth is 1. Overrun cannot occur because input rate ≤1 sample/clk.
- Read timing:
  - RAM read latency is 1 cycle, plus an output register.
  - Output sample 0 appears 2 cycles after entry to READ, i.e. 3 cycles after the last write.
  - o_data_valid is high for exactly N contiguous cycles per bank, regardless of input gaps.
- Output flags:
  - o_ant_sel is high when (output index mod ANT_NUM)==0.
  - o_fram_hd is high only on index 0 of a frame-first bank.
- A header during READ does not disturb the bank being read.
- Duplicate map fields without MAP_CHECK_EN:
  - Colliding slots overwrite the same address, in write order, so the last one wins.
  - Unwritten addresses output stale RAM contents.
- Reset mid-operation aborts read and write immediately. Nothing is output until a new full bank completes.

Optional Feature:
MAP_CHECK_EN defined:
- On latch, the map is checked for duplicates, using a registered permutation check with 1-cycle latency.
- If a duplicate is found, o_map_err is set and held until the next valid-map header or reset, and the identity map is used for that frame.
- Data written during the 1-cycle check uses the identity map.

MAP_CHECK_EN undefined:
- No check logic; o_map_err is tied 0 and the map is used as given.

Test Plan:
All scenarios use ANT_NUM=8, ANT_W=3, GRP=4, DW=32.
1. Identity map 0xFAC688, header, then 32 back-to-back valid samples with data=n -> output 0..31 starting 3 cycles after the last write; o_fram_hd with 0; o_ant_sel with 0,8,16,24; o_data_valid high for 32 cycles.
2. Reverse map 0x053977, same stimulus -> output 7,6,..,0,15,..,8,23..16,31..24.
3. Identity map, valid every other cycle for 32 samples -> same sequence as scenario 1 as one contiguous 32-cycle burst.
4. Header, 13 samples, header, then 32 samples n=100.. -> o_trunc single pulse on the 2nd header; outputs only 100..131 with o_fram_hd on 100.
5. Map all-zero with MAP_CHECK_EN defined -> o_map_err=1, output identical to identity (0..31). Without the macro -> address 8g holds input 8g+7; other addresses stale.
6. asy_rst_n pulsed low at output index 10 -> all outputs 0 immediately; no o_data_valid until a fresh 32-sample bank, then 3-cycle latency holds.
